// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding bus access per request, stalling the pipeline until it completes.
// Optional bus-wait abort is compiled in with `define LSU_TIMEOUT_EN (limit set by TIMEOUT).
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    output logic        bus_read,
    output logic        bus_write,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_error
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } lsuState_t;

    lsuState_t   state_r;
    lsuState_t   stateNext_s;
    logic [1:0]  addrOff_r;
    logic [2:0]  funct3_r;
    logic        isWrite_r;
    logic [31:0] busAddr_r;
    logic [31:0] busWdata_r;
    logic [3:0]  busSel_r;
    logic        busRead_r;
    logic        busWrite_r;
    logic [31:0] loadData_r;
    logic        misaligned_r;
    logic        reqValid_s;
    logic        isWriteReq_s;
    logic        misalign_s;
    logic        accept_s;
    logic        timeout_s;

    // funct3[1:0] encodes access size for loads and stores alike: 00 byte, 01 half, 10 word
    function automatic logic isMisaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   isMisaligned = 1'b0;
            2'b01:   isMisaligned = off[0];
            default: isMisaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] laneSel(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   laneSel = 4'b0001 << off;
            2'b01:   laneSel = 4'b0011 << off;
            default: laneSel = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] storeLanes(input logic [2:0] f3, input logic [31:0] sd);
        case (f3[1:0])
            2'b00:   storeLanes = {4{sd[7:0]}};
            2'b01:   storeLanes = {2{sd[15:0]}};
            default: storeLanes = sd;
        endcase
    endfunction

    function automatic logic [31:0] extendLoad(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rd);
        logic [7:0]  laneByte;
        logic [15:0] laneHalf;
        laneByte = rd[{off, 3'b000} +: 8];
        laneHalf = rd[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  extendLoad = {{24{laneByte[7]}}, laneByte};
            3'b001:  extendLoad = {{16{laneHalf[15]}}, laneHalf};
            3'b100:  extendLoad = {24'h000000, laneByte};
            3'b101:  extendLoad = {16'h0000, laneHalf};
            default: extendLoad = rd;
        endcase
    endfunction

    // a simultaneous read and write request is served as a read
    assign reqValid_s   = mem_read | mem_write;
    assign isWriteReq_s = mem_write & ~mem_read;
    assign misalign_s   = isMisaligned(funct3, alu_result[1:0]);
    assign accept_s     = (state_r == IDLE) & reqValid_s & ~misalign_s;

    assign stall      = (state_r == BUSY) | accept_s;
    assign bus_addr   = busAddr_r;
    assign bus_wdata  = busWdata_r;
    assign bus_sel    = busSel_r;
    assign bus_read   = busRead_r;
    assign bus_write  = busWrite_r;
    assign load_data  = loadData_r;
    assign misaligned = misaligned_r;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] busyCnt_r;
    logic             busError_r;

    assign timeout_s = (state_r == BUSY) & ~bus_ack & (busyCnt_r == CNT_W'(TIMEOUT - 1));
    assign bus_error = busError_r;

    // BUSY-cycle counter and one-cycle abort flag
    always_ff @(posedge clk) begin
        if (rst) begin
            busyCnt_r  <= {CNT_W{1'b0}};
            busError_r <= 1'b0;
        end else begin
            busError_r <= timeout_s;
            if ((state_r == BUSY) && !bus_ack && !timeout_s) begin
                busyCnt_r <= busyCnt_r + CNT_W'(1);
            end else begin
                busyCnt_r <= {CNT_W{1'b0}};
            end
        end
    end
`else
    assign timeout_s = 1'b0;
    assign bus_error = 1'b0;
`endif

    // next-state decode
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    stateNext_s = BUSY;
                end else begin
                    stateNext_s = IDLE;
                end
            end
            BUSY: begin
                if (bus_ack || timeout_s) begin
                    stateNext_s = DONE;
                end else begin
                    stateNext_s = BUSY;
                end
            end
            DONE:    stateNext_s = IDLE;
            default: stateNext_s = IDLE;
        endcase
    end

    // state, latched request and registered bus/result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            addrOff_r    <= 2'b00;
            funct3_r     <= 3'b000;
            isWrite_r    <= 1'b0;
            busAddr_r    <= 32'h0000_0000;
            busWdata_r   <= 32'h0000_0000;
            busSel_r     <= 4'b0000;
            busRead_r    <= 1'b0;
            busWrite_r   <= 1'b0;
            loadData_r   <= 32'h0000_0000;
            misaligned_r <= 1'b0;
        end else begin
            state_r      <= stateNext_s;
            misaligned_r <= (state_r == IDLE) & reqValid_s & misalign_s;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        addrOff_r  <= alu_result[1:0];
                        funct3_r   <= funct3;
                        isWrite_r  <= isWriteReq_s;
                        busAddr_r  <= {alu_result[31:2], 2'b00};
                        busSel_r   <= laneSel(funct3, alu_result[1:0]);
                        busWdata_r <= isWriteReq_s ? storeLanes(funct3, store_data) : 32'h0000_0000;
                        busRead_r  <= ~isWriteReq_s;
                        busWrite_r <= isWriteReq_s;
                    end
                end
                BUSY: begin
                    if (bus_ack || timeout_s) begin
                        busAddr_r  <= 32'h0000_0000;
                        busWdata_r <= 32'h0000_0000;
                        busSel_r   <= 4'b0000;
                        busRead_r  <= 1'b0;
                        busWrite_r <= 1'b0;
                    end
                    if (bus_ack) begin
                        if (!isWrite_r) begin
                            loadData_r <= extendLoad(funct3_r, addrOff_r, bus_rdata);
                        end
                    end else if (timeout_s) begin
                        loadData_r <= 32'h0000_0000;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: per-cycle expectations derived from a transaction timeline
// and plain-arithmetic lane/extension model, checked on every falling edge.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic [31:0] load_data;
    logic        stall;
    logic        misaligned;
    logic        bus_error;

    int vectors = 0;
    int miscompares = 0;

    logic        chkEn = 1'b0;
    logic        expStall, expRead, expWrite, expMis, expErr;
    logic [31:0] expAddr, expWdata, expLoad;
    logic [3:0]  expSel;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .alu_result(alu_result), .store_data(store_data), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_sel(bus_sel), .bus_read(bus_read), .bus_write(bus_write),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .load_data(load_data), .stall(stall),
        .misaligned(misaligned), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // reference model: spec rules in plain arithmetic
    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] d);
        logic [31:0] v;
        int sh;
        sh = 8 * int'(a % 32'd4);
        case (f3)
            3'b000: begin v = (d >> sh) & 32'hFF; if (v >= 32'd128) v = v + 32'hFFFF_FF00; end
            3'b100: v = (d >> sh) & 32'hFF;
            3'b001: begin
                v = (d >> (16 * int'((a / 32'd2) % 32'd2))) & 32'hFFFF;
                if (v >= 32'h8000) v = v + 32'hFFFF_0000;
            end
            3'b101: v = (d >> (16 * int'((a / 32'd2) % 32'd2))) & 32'hFFFF;
            default: v = d;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] modelSel(input logic [2:0] f3, input logic [31:0] a);
        int bytes;
        int mask;
        bytes = 1 << int'(f3 % 3'd4);
        mask  = (1 << bytes) - 1;
        return 32'(mask << int'(a % 32'd4));
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] sd);
        case (f3 % 3'd4)
            3'd0:    return (sd & 32'hFF) * 32'h0101_0101;
            3'd1:    return (sd & 32'hFFFF) * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    // single compare process
    always @(negedge clk) begin
        if (chkEn) begin
            check("stall", {31'b0, stall}, {31'b0, expStall});
            check("bus_read", {31'b0, bus_read}, {31'b0, expRead});
            check("bus_write", {31'b0, bus_write}, {31'b0, expWrite});
            check("bus_sel", {28'b0, bus_sel}, {28'b0, expSel});
            check("bus_wdata", bus_wdata, expWdata);
            if (expRead || expWrite) check("bus_addr", bus_addr, expAddr);
            check("load_data", load_data, expLoad);
            check("misaligned", {31'b0, misaligned}, {31'b0, expMis});
            check("bus_error", {31'b0, bus_error}, {31'b0, expErr});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleExp();
        expStall = 1'b0; expRead = 1'b0; expWrite = 1'b0; expSel = 4'b0000;
        expWdata = 32'h0; expMis = 1'b0; expErr = 1'b0;
    endtask

    // present a request in the current (IDLE) cycle
    task automatic issue(input logic isRead, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd);
        mem_read = isRead; mem_write = ~isRead; funct3 = f3; alu_result = a; store_data = sd;
        idleExp();
        expStall = 1'b1;
    endtask

    // BUSY cycles (ack on the last unless ackIt=0), then DONE, then one quiet IDLE cycle
    task automatic finish(input logic isRead, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rd, input int nBusy,
                          input logic ackIt, input logic reqInDone);
        for (int i = 1; i <= nBusy; i++) begin
            step();
            mem_read = 1'b0; mem_write = 1'b0; alu_result = 32'h0; store_data = 32'h0;
            bus_ack   = ackIt && (i == nBusy);
            bus_rdata = bus_ack ? rd : 32'h5A5A_A5A5;
            expStall = 1'b1; expRead = isRead; expWrite = ~isRead;
            expAddr  = a & 32'hFFFF_FFFC;
            expSel   = 4'(modelSel(f3, a));
            expWdata = isRead ? 32'h0 : modelWdata(f3, sd);
        end
        step();
        bus_ack = 1'b0; mem_read = reqInDone;
        idleExp();
        if (!ackIt) begin
            expLoad = 32'h0; expErr = 1'b1;
        end else if (isRead) begin
            expLoad = modelLoad(f3, a, rd);
        end
        step();
        mem_read = 1'b0;
        idleExp();
    endtask

    task automatic xfer(input logic isRead, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd, input int nBusy,
                        input logic reqInDone);
        step();
        issue(isRead, f3, a, sd);
        finish(isRead, f3, a, sd, rd, nBusy, 1'b1, reqInDone);
    endtask

    task automatic misalignedReq(input logic [2:0] f3, input logic [31:0] a);
        step();
        mem_read = 1'b1; mem_write = 1'b0; funct3 = f3; alu_result = a;
        idleExp();
        step();
        mem_read = 1'b0;
        idleExp(); expMis = 1'b1;
        step();
        idleExp();
    endtask

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000; alu_result = 32'h0;
        store_data = 32'h0; bus_rdata = 32'h0; bus_ack = 1'b0;

        // pin the model with hand-computed values
        check("pin_lb", modelLoad(3'b000, 32'h103, 32'h80FF_FFFF), 32'hFFFF_FF80);
        check("pin_lbu", modelLoad(3'b100, 32'h103, 32'h80FF_FFFF), 32'h0000_0080);
        check("pin_lh", modelLoad(3'b001, 32'h102, 32'h8001_1234), 32'hFFFF_8001);
        check("pin_sh_sel", modelSel(3'b001, 32'h202), 32'h0000_000C);
        check("pin_sh_wdata", modelWdata(3'b001, 32'h1234_ABCD), 32'hABCD_ABCD);
        check("pin_sb_wdata", modelWdata(3'b000, 32'h0000_00A5), 32'hA5A5_A5A5);
        check("pin_lw_sel", modelSel(3'b010, 32'h100), 32'h0000_000F);

        // reset state
        step(); step();
        idleExp(); expAddr = 32'h0; expLoad = 32'h0;
        chkEn = 1'b1;
        step();
        rst = 1'b0;

        xfer(1'b1, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 2, 1'b1);     // LW, request in DONE ignored
        xfer(1'b1, 3'b000, 32'h103, 32'h0, 32'h80FF_FFFF, 1, 1'b0);     // LB
        xfer(1'b1, 3'b100, 32'h103, 32'h0, 32'h80FF_FFFF, 3, 1'b0);     // LBU
        xfer(1'b0, 3'b001, 32'h202, 32'h1234_ABCD, 32'hFFFF_FFFF, 2, 1'b0); // SH, load_data kept
        misalignedReq(3'b010, 32'h101);
        misalignedReq(3'b001, 32'h001);

        // ack while idle must be ignored
        step();
        bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        idleExp();
        step();
        bus_ack = 1'b0;
        idleExp();

        xfer(1'b1, 3'b001, 32'h102, 32'h0, 32'h8001_1234, 1, 1'b0);     // LH
        xfer(1'b1, 3'b101, 32'h000, 32'h0, 32'h1234_F00F, 2, 1'b0);     // LHU
        xfer(1'b0, 3'b000, 32'h001, 32'h0000_00A5, 32'h0, 1, 1'b0);     // SB
        xfer(1'b0, 3'b010, 32'h010, 32'h0123_4567, 32'h0, 1, 1'b0);     // SW
        step(); mem_read = 1'b1; mem_write = 1'b1; funct3 = 3'b010; alu_result = 32'h20;
        idleExp(); expStall = 1'b1;                                       // both high -> read
        finish(1'b1, 3'b010, 32'h20, 32'h0, 32'h7654_3210, 1, 1'b1, 1'b0);

        // reset in the second BUSY cycle, then a request right after reset
        step();
        issue(1'b1, 3'b010, 32'h100, 32'h0);
        for (int i = 1; i <= 2; i++) begin
            step();
            mem_read = 1'b0; bus_ack = 1'b0;
            expStall = 1'b1; expRead = 1'b1; expWrite = 1'b0; expAddr = 32'h100;
            expSel = 4'b1111; expWdata = 32'h0;
            if (i == 2) rst = 1'b1;
        end
        step();
        rst = 1'b0;
        expLoad = 32'h0;
        issue(1'b1, 3'b010, 32'h300, 32'h0);
        finish(1'b1, 3'b010, 32'h300, 32'h0, 32'h1122_3344, 1, 1'b1, 1'b0);

`ifdef LSU_TIMEOUT_EN
        step();
        issue(1'b1, 3'b010, 32'h400, 32'h0);
        finish(1'b1, 3'b010, 32'h400, 32'h0, 32'h0, 4, 1'b0, 1'b0);
`endif

        step();
        @(negedge clk);
        #1;
        chkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
